// File: rtl/spi_reg_bank_arbiter_if.sv
// Bus bundle between the two requesters (SPI slave port and local host port)
// and the register bank arbiter.
//   master : requester side. Drives SPI address/data/strobe and the host
//            req/we/addr/wdata; receives spi_rdata and the host gnt/rdata/rvalid.
//   slave  : arbiter side. Mirror of master.
interface spi_reg_bank_arbiter_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned REG_W  = 8
);
  logic [ADDR_W-1:0] spi_addr;
  logic [REG_W-1:0]  spi_wdata;
  logic              spi_wr_dv;
  logic [REG_W-1:0]  spi_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [REG_W-1:0]  host_wdata;
  logic              host_gnt;
  logic [REG_W-1:0]  host_rdata;
  logic              host_rvalid;

  modport master (
    output spi_addr, spi_wdata, spi_wr_dv,
    output host_req, host_we, host_addr, host_wdata,
    input  spi_rdata, host_gnt, host_rdata, host_rvalid
  );

  modport slave (
    input  spi_addr, spi_wdata, spi_wr_dv,
    input  host_req, host_we, host_addr, host_wdata,
    output spi_rdata, host_gnt, host_rdata, host_rvalid
  );
endinterface

// File: rtl/spi_reg_bank_arbiter.sv
// Register bank shared between an SPI slave port and a local host port.
// SPI writes are unstallable strobes and always win; the host waits via req/gnt.
// A sticky per-register bitmap flags registers changed by SPI; a host read of
// a register clears its bit.
// Ports:
//   clk, rstb    : clock, asynchronous active-low reset
//   ena          : global enable; low freezes all state and blocks grants
//   bus (slave)  : SPI addr/wdata/wr_dv/rdata and host req/we/addr/wdata/gnt/rdata/rvalid
//   reg_changed  : bit i set by an accepted SPI write to register i
//   spi_wr_drop  : one-cycle pulse after an SPI write to a read-only register
module spi_reg_bank_arbiter #(
  parameter int unsigned           ADDR_W  = 3,
  parameter int unsigned           REG_W   = 8,
  parameter logic [2**ADDR_W-1:0] RO_MASK = '0
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   ena,
  spi_reg_bank_arbiter_if.slave  bus,
  output logic [2**ADDR_W-1:0]   reg_changed,
  output logic                   spi_wr_drop
);

  localparam int unsigned Depth = 2**ADDR_W;

  typedef enum logic {StIdle, StRdResp} state_e;

  state_e            state_q, state_d;
  logic [REG_W-1:0]  bank_q [Depth];
  logic [REG_W-1:0]  bank_d [Depth];
  logic [Depth-1:0]  changed_q, changed_d;
  logic [REG_W-1:0]  rdata_q, rdata_d;
  logic              drop_q, drop_d;

  logic spi_wr_ok;
  logic host_wr;
  logic host_rd;

  assign spi_wr_ok = ena & bus.spi_wr_dv & ~RO_MASK[bus.spi_addr];
  assign host_wr   = bus.host_gnt & bus.host_we;
  assign host_rd   = bus.host_gnt & ~bus.host_we;

  // State register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (ena) begin
      unique case (state_q)
        StIdle:   if (host_rd) state_d = StRdResp;
        StRdResp: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // FSM outputs; grant is blocked by a concurrent SPI strobe so the two
  // write ports and the changed-bit set/clear can never collide.
  always_comb begin
    bus.host_gnt    = 1'b0;
    bus.host_rvalid = 1'b0;
    unique case (state_q)
      StIdle:   bus.host_gnt    = ena & bus.host_req & ~bus.spi_wr_dv;
      StRdResp: bus.host_rvalid = ena;
      default:  ;
    endcase
  end

  // Bank, changed bitmap, read data and drop flag next-state
  always_comb begin
    bank_d    = bank_q;
    changed_d = changed_q;
    rdata_d   = rdata_q;
    drop_d    = drop_q;
    if (ena) begin
      drop_d = bus.spi_wr_dv & RO_MASK[bus.spi_addr];
      if (host_wr) begin
        bank_d[bus.host_addr] = bus.host_wdata;
      end
      if (host_rd) begin
        rdata_d                  = bank_q[bus.host_addr];
        changed_d[bus.host_addr] = 1'b0;
      end
      if (spi_wr_ok) begin
        bank_d[bus.spi_addr]    = bus.spi_wdata;
        changed_d[bus.spi_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < int'(Depth); i++) begin
        bank_q[i] <= '0;
      end
      changed_q <= '0;
      rdata_q   <= '0;
      drop_q    <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      changed_q <= changed_d;
      rdata_q   <= rdata_d;
      drop_q    <= drop_d;
    end
  end

  // No write bypass: SPI sees a new value the cycle after the write edge
  assign bus.spi_rdata  = bank_q[bus.spi_addr];
  assign bus.host_rdata = rdata_q;
  assign reg_changed    = changed_q;
  // A drop pulse pending across an ena-low stretch is shown once ena returns
  assign spi_wr_drop    = drop_q & ena;

endmodule

// File: tb/tb_spi_reg_bank_arbiter.sv
module tb_spi_reg_bank_arbiter;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned REG_W  = 8;
  localparam int unsigned Depth  = 2**ADDR_W;
  localparam logic [Depth-1:0] RoMask = 8'h80;

  logic clk;
  logic rstb;
  logic ena;
  logic [Depth-1:0] reg_changed;
  logic spi_wr_drop;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  spi_reg_bank_arbiter_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  spi_reg_bank_arbiter #(
    .ADDR_W  (ADDR_W),
    .REG_W   (REG_W),
    .RO_MASK (RoMask)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .bus         (bus),
    .reg_changed (reg_changed),
    .spi_wr_drop (spi_wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: bank contents, changed flags, and whether a
  // host read response is owed this cycle.
  logic [REG_W-1:0] m_bank [Depth];
  logic [Depth-1:0] m_chg;
  logic             m_resp_due;
  logic [REG_W-1:0] m_rdata;
  logic             m_drop;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < int'(Depth); i++) m_bank[i] = '0;
      m_chg      = '0;
      m_resp_due = 1'b0;
      m_rdata    = '0;
      m_drop     = 1'b0;
    end else if (ena) begin
      logic granted;
      granted    = bus.host_req && !bus.spi_wr_dv && !m_resp_due;
      m_resp_due = 1'b0;
      if (granted && bus.host_we) m_bank[bus.host_addr] = bus.host_wdata;
      if (granted && !bus.host_we) begin
        m_rdata              = m_bank[bus.host_addr];
        m_chg[bus.host_addr] = 1'b0;
        m_resp_due           = 1'b1;
      end
      m_drop = bus.spi_wr_dv && RoMask[bus.spi_addr];
      if (bus.spi_wr_dv && !RoMask[bus.spi_addr]) begin
        m_bank[bus.spi_addr] = bus.spi_wdata;
        m_chg[bus.spi_addr]  = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_gnt", 32'(bus.host_gnt),
          32'(ena && bus.host_req && !bus.spi_wr_dv && !m_resp_due));
      chk("m_rvalid", 32'(bus.host_rvalid), 32'(ena && m_resp_due));
      chk("m_rdata", 32'(bus.host_rdata), 32'(m_rdata));
      chk("m_changed", 32'(reg_changed), 32'(m_chg));
      chk("m_drop", 32'(spi_wr_drop), 32'(m_drop && ena));
      chk("m_spi_rdata", 32'(bus.spi_rdata), 32'(m_bank[bus.spi_addr]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_idle();
    bus.spi_wr_dv = 1'b0;
  endtask

  initial begin
    rstb = 1'b0;
    ena  = 1'b1;
    bus.spi_addr   = '0;
    bus.spi_wdata  = '0;
    bus.spi_wr_dv  = 1'b0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    repeat (3) tick();
    rstb = 1'b1;
    cmp_on = 1'b1;

    // Reset state
    for (int a = 0; a < int'(Depth); a++) begin
      bus.spi_addr = ADDR_W'(a);
      #1;
      chk("rst_spi_rdata", 32'(bus.spi_rdata), 32'h0);
    end
    chk("rst_changed", 32'(reg_changed), 32'h0);
    chk("rst_gnt", 32'(bus.host_gnt), 32'h0);
    chk("rst_rvalid", 32'(bus.host_rvalid), 32'h0);
    tick();

    // SPI write
    bus.spi_addr = 3'd3; bus.spi_wdata = 8'hA5; bus.spi_wr_dv = 1'b1;
    tick();
    spi_idle();
    @(negedge clk);
    chk("spi_wr_rdata", 32'(bus.spi_rdata), 32'hA5);
    chk("spi_wr_changed", 32'(reg_changed), 32'h08);
    tick();

    // Collision: SPI wins, host granted next cycle and lands last
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 3'd3; bus.host_wdata = 8'h5A;
    bus.spi_addr = 3'd3; bus.spi_wdata = 8'hA5; bus.spi_wr_dv = 1'b1;
    @(negedge clk);
    chk("coll_gnt_blocked", 32'(bus.host_gnt), 32'h0);
    tick();
    spi_idle();
    @(negedge clk);
    chk("coll_gnt_retry", 32'(bus.host_gnt), 32'h1);
    tick();
    bus.host_req = 1'b0;
    @(negedge clk);
    chk("coll_bank3", 32'(bus.spi_rdata), 32'h5A);
    tick();

    // Host read clears the changed bit
    bus.spi_wdata = 8'hA5; bus.spi_wr_dv = 1'b1;
    tick();
    spi_idle();
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 3'd3;
    @(negedge clk);
    chk("rd_gnt", 32'(bus.host_gnt), 32'h1);
    tick();
    bus.host_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", 32'(bus.host_rvalid), 32'h1);
    chk("rd_rdata", 32'(bus.host_rdata), 32'hA5);
    chk("rd_changed3", 32'(reg_changed[3]), 32'h0);
    tick();
    @(negedge clk);
    chk("rd_rvalid_pulse", 32'(bus.host_rvalid), 32'h0);
    chk("rd_rdata_hold", 32'(bus.host_rdata), 32'hA5);
    tick();

    // Read-only register
    bus.spi_addr = 3'd7; bus.spi_wdata = 8'hFF; bus.spi_wr_dv = 1'b1;
    tick();
    spi_idle();
    @(negedge clk);
    chk("ro_drop", 32'(spi_wr_drop), 32'h1);
    chk("ro_bank7", 32'(bus.spi_rdata), 32'h0);
    chk("ro_changed", 32'(reg_changed), 32'h0);
    tick();
    @(negedge clk);
    chk("ro_drop_pulse", 32'(spi_wr_drop), 32'h0);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 3'd7; bus.host_wdata = 8'h11;
    tick();
    bus.host_req = 1'b0;
    @(negedge clk);
    chk("ro_host_wr", 32'(bus.spi_rdata), 32'h11);
    tick();

    // ena low: no grant, SPI ignored
    ena = 1'b0;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 3'd2; bus.host_wdata = 8'h33;
    bus.spi_addr = 3'd2; bus.spi_wdata = 8'h77; bus.spi_wr_dv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ena_no_gnt", 32'(bus.host_gnt), 32'h0);
      tick();
    end
    spi_idle();
    chk("ena_spi_ignored", 32'(bus.spi_rdata), 32'h0);
    ena = 1'b1;
    @(negedge clk);
    chk("ena_gnt_back", 32'(bus.host_gnt), 32'h1);
    tick();
    bus.host_req = 1'b0;
    @(negedge clk);
    chk("ena_host_wr", 32'(bus.spi_rdata), 32'h33);
    tick();

    // Reset during the read response aborts it
    bus.spi_addr = 3'd7; bus.spi_wdata = 8'h42; bus.spi_wr_dv = 1'b0;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 3'd7;
    @(negedge clk);
    chk("abort_gnt", 32'(bus.host_gnt), 32'h1);
    tick();
    bus.host_req = 1'b0;
    rstb = 1'b0;
    #1;
    chk("abort_rvalid", 32'(bus.host_rvalid), 32'h0);
    chk("abort_rdata", 32'(bus.host_rdata), 32'h0);
    chk("abort_bank7", 32'(bus.spi_rdata), 32'h0);
    chk("abort_changed", 32'(reg_changed), 32'h0);
    tick();
    tick();
    rstb = 1'b1;
    tick();

    // Randomized traffic; the host holds each request until granted
    begin
      bit gnt_seen;
      for (int c = 0; c < 3000; c++) begin
        if (bus.host_req && gnt_seen) bus.host_req = 1'b0;
        if (!bus.host_req && ($urandom_range(0, 1) == 1)) begin
          bus.host_req   = 1'b1;
          bus.host_we    = 1'($urandom_range(0, 1));
          bus.host_addr  = ADDR_W'($urandom_range(0, Depth - 1));
          bus.host_wdata = REG_W'($urandom);
        end
        bus.spi_wr_dv = ($urandom_range(0, 3) == 0);
        bus.spi_addr  = ADDR_W'($urandom_range(0, Depth - 1));
        bus.spi_wdata = REG_W'($urandom);
        ena = ($urandom_range(0, 15) != 0);
        @(negedge clk);
        gnt_seen = bus.host_gnt;
        tick();
      end
    end

    bus.host_req = 1'b0;
    bus.spi_wr_dv = 1'b0;
    ena = 1'b1;
    tick();
    tick();
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
